// File: rtl/uart_mmio.sv
// uart_mmio: word-wide valid/ready register bridge in front of the UART core.
// Adds a one-byte TX hold register and a one-byte RX prefetch register.
//
// Parameter:
//   WAIT_LIMIT  max stall cycles for a DATA write on a full hold (0 = forever)
// Optional feature macro:
//   UART_MMIO_IRQ_EN  enables CTRL (bit0 rx irq en, bit1 tx irq en) and irq
// Ports:
//   clk, rst_n        clock, async active-low reset
//   bus_valid/we      request strobe and direction
//   bus_addr          0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   bus_wdata/wstrb   write data and byte enables (only wstrb[0] used)
//   bus_ready/rdata   one-cycle registered response and read data
//   tx_available/data byte offered to the UART, tx_ack when taken
//   rx_data/rx_ack    FIFO head from the UART, rx_pop requests it
//   irq               registered level interrupt
module uart_mmio #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        tx_available,
  output logic [7:0]  tx_data,
  input  logic        tx_ack,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  input  logic        rx_ack,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TX,
    RESP
  } state_e;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;

  localparam int CW =
    (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(WAIT_LIMIT - 1);

  state_e        state_q, state_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          hold_valid_q, hold_valid_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic          pf_valid_q, pf_valid_d;
  logic [7:0]    pf_data_q, pf_data_d;
  logic          tx_drop_q, tx_drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rx_pop_q, rx_pop_d;
  logic          irq_q, irq_d;
  logic [1:0]    ctrl_q, ctrl_d;

  logic [31:0]   rd_word;
  logic          load;
  logic          drop;

  logic unused_bits;
  assign unused_bits =
    ^{bus_wdata[31:8], bus_wstrb[3:1]};

  always_comb begin
    rd_word = '0;
    unique case (bus_addr)
      A_DATA: begin
        if (pf_valid_q)
          rd_word = {1'b1, 23'b0, pf_data_q};
      end
      A_STATUS: begin
        rd_word = {29'b0, tx_drop_q,
                   !hold_valid_q, pf_valid_q};
      end
      A_CTRL: begin
`ifdef UART_MMIO_IRQ_EN
        rd_word = {30'b0, ctrl_q};
`else
        rd_word = '0;
`endif
      end
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rdata_d      = '0;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    pf_valid_d   = pf_valid_q;
    pf_data_d    = pf_data_q;
    tx_drop_d    = tx_drop_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    load         = 1'b0;
    drop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_valid) begin
          state_d = RESP;
          if (!bus_we) begin
            rdata_d = rd_word;
            if (bus_addr == A_DATA)
              pf_valid_d = 1'b0;
          end else if (bus_wstrb[0]) begin
            unique case (bus_addr)
              A_DATA: begin
                if (hold_valid_q && !tx_ack)
                  state_d = WAIT_TX;
                else
                  load = 1'b1;
              end
              A_STATUS: begin
                if (bus_wdata[2])
                  tx_drop_d = 1'b0;
              end
              A_CTRL: begin
`ifdef UART_MMIO_IRQ_EN
                ctrl_d = bus_wdata[1:0];
`endif
              end
              default: ;
            endcase
          end
        end
      end
      WAIT_TX: begin
        if (!hold_valid_q || tx_ack) begin
          load    = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else if (WAIT_LIMIT != 0 &&
                     cnt_q == CNT_LAST) begin
          drop    = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ack frees the hold; a same-cycle load refills it
    if (tx_ack)
      hold_valid_d = 1'b0;
    if (load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = bus_wdata[7:0];
    end
    if (drop)
      tx_drop_d = 1'b1;

    // a fresh byte from the UART overrides a same-cycle pop
    if (rx_ack) begin
      pf_valid_d = 1'b1;
      pf_data_d  = rx_data;
    end

    ready_d  = (state_d == RESP);
    rx_pop_d = !pf_valid_d;
`ifdef UART_MMIO_IRQ_EN
    irq_d = (ctrl_d[0] & pf_valid_d) |
            (ctrl_d[1] & !hold_valid_d);
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      pf_valid_q   <= 1'b0;
      pf_data_q    <= '0;
      tx_drop_q    <= 1'b0;
      cnt_q        <= '0;
      rx_pop_q     <= 1'b1;
      irq_q        <= 1'b0;
      ctrl_q       <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      pf_valid_q   <= pf_valid_d;
      pf_data_q    <= pf_data_d;
      tx_drop_q    <= tx_drop_d;
      cnt_q        <= cnt_d;
      rx_pop_q     <= rx_pop_d;
      irq_q        <= irq_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign bus_ready    = ready_q;
  assign bus_rdata    = rdata_q;
  assign tx_available = hold_valid_q;
  assign tx_data      = hold_data_q;
  assign rx_pop       = rx_pop_q;
  assign irq          = irq_q;

endmodule
